gpio_apb_bank: RTL and testbench

- Parametrised APB3 GPIO slave: bank of NUM_PINS bidirectional pins with output data, direction and input-sync registers, plus per-pin edge interrupts.
- Next-generation replacement for the single-register GPIO write path.
- Sits on the peripheral APB bus.
- Drives pad-side `gpio_out`/`gpio_oe` and samples asynchronous `gpio_in`.

---
 rtl/gpio_pkg.sv | 23 ++
 rtl/gpio_in_sync.sv | 36 +++
 rtl/gpio_apb_bank.sv | 171 +++++++++++++++++
 tb/tb_gpio_apb_bank.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared types and constants for the APB GPIO bank: bus FSM states,
// register offsets and IRQ_TYPE encoding.
package gpio_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_t;

  localparam logic [7:0] OFF_DATA_OUT = 8'h00;
  localparam logic [7:0] OFF_DIR      = 8'h04;
  localparam logic [7:0] OFF_DATA_IN  = 8'h08;
  localparam logic [7:0] OFF_IRQ_EN   = 8'h0C;
  localparam logic [7:0] OFF_IRQ_TYPE = 8'h10;
  localparam logic [7:0] OFF_IRQ_STAT = 8'h14;
  localparam logic [7:0] OFF_DATA_SET = 8'h18;
  localparam logic [7:0] OFF_DATA_CLR = 8'h1C;

  localparam logic IRQ_TYPE_RISE = 1'b0;
  localparam logic IRQ_TYPE_FALL = 1'b1;

endpackage

// File: rtl/gpio_in_sync.sv
// Pad input synchroniser: SYNC_STAGES flops into DATA_IN, one more flop
// holding the previous sample, and per-pin rise/fall strobes.
module gpio_in_sync #(
  parameter int NUM_PINS    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PINS-1:0] pins_i,
  output logic [NUM_PINS-1:0] data_in_o,
  output logic [NUM_PINS-1:0] rise_o,
  output logic [NUM_PINS-1:0] fall_o
);

  logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q, sync_d;
  logic [NUM_PINS-1:0]                  prev_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pins_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign data_in_o = sync_q[SYNC_STAGES-1];
  assign rise_o    = data_in_o & ~prev_q;
  assign fall_o    = ~data_in_o & prev_q;

endmodule

// File: rtl/gpio_apb_bank.sv
// APB3 GPIO bank: zero-wait-state slave with output/direction registers,
// synchronised inputs and per-pin edge interrupts.
// Optional GPIO_ATOMIC_SETCLR_EN adds write-only DATA_SET/DATA_CLR ports.
module gpio_apb_bank
  import gpio_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_PINS    = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [NUM_PINS-1:0]   gpio_in,
  output logic [NUM_PINS-1:0]   gpio_out,
  output logic [NUM_PINS-1:0]   gpio_oe,
  output logic                  irq,
  output apb_state_t            dbg_state
);

  // Handshake: a transfer completes in the single cycle where the previous
  // edge recorded a setup phase and psel & penable are both high; pready is
  // asserted for exactly that cycle and the write commits on its closing edge.

  apb_state_t state_q, state_d;

  logic [NUM_PINS-1:0] out_q, out_d;
  logic [NUM_PINS-1:0] dir_q, dir_d;
  logic [NUM_PINS-1:0] en_q, en_d;
  logic [NUM_PINS-1:0] type_q, type_d;
  logic [NUM_PINS-1:0] stat_q, stat_d;
  logic                irq_q;

  logic [NUM_PINS-1:0] data_in, rise, fall, set_bits, clr_bits;
  logic [NUM_PINS-1:0] wdata;
  logic                in_access, we, err, mapped;
  logic                sel_out, sel_dir, sel_in, sel_en, sel_type, sel_stat;
  logic                sel_set, sel_clr;
  logic [DATA_WIDTH-1:0] rd_val;

  gpio_in_sync #(
    .NUM_PINS    (NUM_PINS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .pins_i    (gpio_in),
    .data_in_o (data_in),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  // state_q records the bus phase observed on the previous edge.
  always_ff @(posedge clk) begin
    if (rst) state_q <= APB_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      APB_IDLE: begin
        if (psel && !penable) state_d = APB_SETUP;
      end
      APB_SETUP: begin
        if (psel && penable) state_d = APB_ACCESS;
        else if (psel)       state_d = APB_SETUP;
        else                 state_d = APB_IDLE;
      end
      APB_ACCESS: begin
        if (psel && !penable) state_d = APB_SETUP;
        else                  state_d = APB_IDLE;
      end
      default: state_d = APB_IDLE;
    endcase
  end

  assign in_access = !rst && (state_q == APB_SETUP) && psel && penable;
  assign dbg_state = state_q;
  assign wdata     = pwdata[NUM_PINS-1:0];

  always_comb begin
    sel_out  = (paddr == ADDR_WIDTH'(OFF_DATA_OUT));
    sel_dir  = (paddr == ADDR_WIDTH'(OFF_DIR));
    sel_in   = (paddr == ADDR_WIDTH'(OFF_DATA_IN));
    sel_en   = (paddr == ADDR_WIDTH'(OFF_IRQ_EN));
    sel_type = (paddr == ADDR_WIDTH'(OFF_IRQ_TYPE));
    sel_stat = (paddr == ADDR_WIDTH'(OFF_IRQ_STAT));
`ifdef GPIO_ATOMIC_SETCLR_EN
    sel_set  = (paddr == ADDR_WIDTH'(OFF_DATA_SET));
    sel_clr  = (paddr == ADDR_WIDTH'(OFF_DATA_CLR));
`else
    sel_set  = 1'b0;
    sel_clr  = 1'b0;
`endif
    mapped = sel_out | sel_dir | sel_in | sel_en | sel_type | sel_stat |
             sel_set | sel_clr;
    err    = (paddr[1:0] != 2'b00) || !mapped || (pwrite && sel_in);
  end

  // Bits above NUM_PINS stay zero; SET/CLR read back as zero.
  always_comb begin
    rd_val = '0;
    if (sel_out)  rd_val[NUM_PINS-1:0] = out_q;
    if (sel_dir)  rd_val[NUM_PINS-1:0] = dir_q;
    if (sel_in)   rd_val[NUM_PINS-1:0] = data_in;
    if (sel_en)   rd_val[NUM_PINS-1:0] = en_q;
    if (sel_type) rd_val[NUM_PINS-1:0] = type_q;
    if (sel_stat) rd_val[NUM_PINS-1:0] = stat_q;
  end

  assign we      = in_access && pwrite && !err;
  assign pready  = in_access;
  assign pslverr = in_access && err;
  assign prdata  = (in_access && !pwrite && !err) ? rd_val : '0;

  always_comb begin
    for (int i = 0; i < NUM_PINS; i++) begin
      set_bits[i] = en_q[i] && !dir_q[i] &&
                    ((type_q[i] == IRQ_TYPE_FALL) ? fall[i] : rise[i]);
    end
  end

  always_comb begin
    out_d    = out_q;
    dir_d    = dir_q;
    en_d     = en_q;
    type_d   = type_q;
    clr_bits = '0;
    if (we && sel_out)  out_d  = wdata;
    if (we && sel_dir)  dir_d  = wdata;
    if (we && sel_en)   en_d   = wdata;
    if (we && sel_type) type_d = wdata;
    if (we && sel_stat) clr_bits = wdata;
    if (we && sel_set)  out_d  = out_q | wdata;
    if (we && sel_clr)  out_d  = out_q & ~wdata;
    // A new edge on the same cycle as its W1C keeps the bit set.
    stat_d = (stat_q & ~clr_bits) | set_bits;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      dir_q  <= '0;
      en_q   <= '0;
      type_q <= '0;
      stat_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      en_q   <= en_d;
      type_q <= type_d;
      stat_q <= stat_d;
      irq_q  <= |(stat_q & en_q);
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_apb_bank.sv
// Self-checking bench for gpio_apb_bank: directed cases plus randomized
// register/pad traffic against a behavioural register-map model.
module tb_gpio_apb_bank;
  import gpio_pkg::*;

  localparam int DW = 32;
  localparam int NP = 32;
  localparam int AW = 8;
  localparam int SS = 2;
  localparam logic [31:0] MASK = (NP == 32) ? 32'hFFFF_FFFF : ((32'd1 << NP) - 32'd1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic [DW-1:0] prdata;
  logic          pready, pslverr, irq;
  logic [NP-1:0] gpio_in = '0;
  logic [NP-1:0] gpio_out, gpio_oe;
  apb_state_t    dbg_state;

  gpio_apb_bank #(
    .DATA_WIDTH (DW), .NUM_PINS (NP), .ADDR_WIDTH (AW), .SYNC_STAGES (SS)
  ) dut (
    .clk (clk), .rst (rst), .psel (psel), .penable (penable),
    .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata), .prdata (prdata),
    .pready (pready), .pslverr (pslverr), .gpio_in (gpio_in),
    .gpio_out (gpio_out), .gpio_oe (gpio_oe), .irq (irq),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model of the visible register map.
  logic [31:0] out_m, dir_m, en_m, type_m, stat_m, pad_m;
  logic [31:0] acc_out;
  logic [31:0] r;
  logic        e, y;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic model_reset();
    out_m = 0; dir_m = 0; en_m = 0; type_m = 0; stat_m = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; psel = 0; penable = 0; pwrite = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One complete APB transfer; returns with the bus idle, 1 time unit after
  // the commit edge. acc_out captures gpio_out during the access phase.
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output logic rdy);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1;
    #1;
    rd = prdata; er = pslverr; rdy = pready; acc_out = 32'(gpio_out);
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_wr(input logic [7:0] addr, input logic [31:0] wd);
    logic [31:0] rd_t; logic er_t, rdy_t;
    apb_xfer(1'b1, addr, wd, rd_t, er_t, rdy_t);
  endtask

  function automatic logic [31:0] model_rd(input logic [7:0] addr);
    case (addr)
      8'h00: return out_m;
      8'h04: return dir_m;
      8'h08: return pad_m & MASK;
      8'h0C: return en_m;
      8'h10: return type_m;
      8'h14: return stat_m;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_wr(input logic [7:0] addr, input logic [31:0] d);
    case (addr)
      8'h00: out_m  = d & MASK;
      8'h04: dir_m  = d & MASK;
      8'h0C: en_m   = d & MASK;
      8'h10: type_m = d & MASK;
      8'h14: stat_m = stat_m & ~d;
      default: ;
    endcase
  endtask

  // Change the pads, let the change propagate, apply the edge rules.
  task automatic pad_change(input logic [31:0] nv);
    logic [31:0] rise, fall;
    @(posedge clk); #1;
    gpio_in = nv[NP-1:0];
    rise = nv & ~pad_m & MASK;
    fall = ~nv & pad_m & MASK;
    stat_m = stat_m | (en_m & ~dir_m & ((type_m & fall) | (~type_m & rise)));
    pad_m = nv & MASK;
    repeat (SS + 4) @(posedge clk);
    #1;
  endtask

  logic [7:0] rw_addrs [5] = '{8'h00, 8'h04, 8'h0C, 8'h10, 8'h14};
  logic [7:0] rd_addrs [6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};

  initial begin
    pad_m = 0;
    do_reset();

    // Reset state.
    check_eq("rst_state", 32'(dbg_state), 32'(APB_IDLE));
    check_eq("rst_oe", 32'(gpio_oe), 0);
    check_eq("rst_out", 32'(gpio_out), 0);
    check_eq("rst_irq", 32'(irq), 0);
    for (int i = 0; i < 6; i++) begin
      apb_xfer(1'b0, rd_addrs[i], 0, r, e, y);
      check_eq($sformatf("rst_rd_%02h", rd_addrs[i]), r, 0);
      check_eq($sformatf("rst_err_%02h", rd_addrs[i]), 32'(e), 0);
    end

    // Output data and direction.
    apb_wr(8'h04, 32'h0000FFFF);
    check_eq("dir_oe", 32'(gpio_oe), 32'h0000FFFF);
    apb_wr(8'h00, 32'hA5A5A5A5);
    check_eq("out_during_access", acc_out, 0);
    check_eq("out_after_commit", 32'(gpio_out), 32'hA5A5A5A5);
    apb_xfer(1'b0, 8'h00, 0, r, e, y);
    check_eq("out_readback", r, 32'hA5A5A5A5);
    apb_xfer(1'b0, 8'h04, 0, r, e, y);
    check_eq("dir_readback", r, 32'h0000FFFF);

    // Interrupt latency, W1C and set-beats-clear.
    apb_wr(8'h04, 0);
    apb_wr(8'h0C, 1);
    apb_wr(8'h10, 0);
    @(posedge clk); #1;
    gpio_in[0] = 1'b1;
    repeat (SS + 1) @(posedge clk);
    #1;
    check_eq("irq_early", 32'(irq), 0);
    @(posedge clk); #1;
    check_eq("irq_latency", 32'(irq), 1);
    apb_wr(8'h14, 1);
    @(posedge clk); #1;
    check_eq("irq_w1c", 32'(irq), 0);
    gpio_in[0] = 1'b0;
    repeat (SS + 4) @(posedge clk);
    #1;
    apb_xfer(1'b0, 8'h14, 0, r, e, y);
    check_eq("fall_ignored", r, 0);
    @(posedge clk); #1;
    gpio_in[0] = 1'b1;
    apb_wr(8'h14, 1);
    apb_xfer(1'b0, 8'h14, 0, r, e, y);
    check_eq("set_beats_clr", r, 1);
    apb_wr(8'h0C, 0);
    apb_xfer(1'b0, 8'h14, 0, r, e, y);
    check_eq("en0_keeps_stat", r, 1);

    // Error responses.
    apb_xfer(1'b1, 8'h08, 32'hFFFFFFFF, r, e, y);
    check_eq("wr_in_err", 32'(e), 1);
    check_eq("wr_in_rdy", 32'(y), 1);
    apb_xfer(1'b0, 8'h08, 0, r, e, y);
    check_eq("data_in_kept", r, 32'h1);
    apb_xfer(1'b0, 8'h24, 0, r, e, y);
    check_eq("unmapped_err", 32'(e), 1);
    check_eq("unmapped_rd", r, 0);
    apb_xfer(1'b0, 8'h02, 0, r, e, y);
    check_eq("misalign_err", 32'(e), 1);
    check_eq("misalign_rd", r, 0);

    // Access without setup phase is ignored.
    @(posedge clk); #1;
    psel = 1; penable = 1; pwrite = 1; paddr = 8'h00; pwdata = 32'h12345678;
    #1;
    check_eq("nosetup_rdy", 32'(pready), 0);
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0;
    apb_xfer(1'b0, 8'h00, 0, r, e, y);
    check_eq("nosetup_nowr", r, 32'hA5A5A5A5);

    // Back-to-back write then read with no idle cycle.
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 8'h10; pwdata = 32'h0F0F00FF;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    penable = 0; pwrite = 0;
    @(posedge clk); #1;
    penable = 1;
    #1;
    check_eq("b2b_rdy", 32'(pready), 1);
    check_eq("b2b_rd", prdata, 32'h0F0F00FF);
    @(posedge clk); #1;
    psel = 0; penable = 0;

`ifdef GPIO_ATOMIC_SETCLR_EN
    apb_wr(8'h00, 32'h0F);
    apb_xfer(1'b1, 8'h18, 32'hF0, r, e, y);
    check_eq("set_err", 32'(e), 0);
    apb_wr(8'h1C, 32'h03);
    check_eq("setclr_out", 32'(gpio_out), 32'hFC);
    apb_xfer(1'b0, 8'h18, 0, r, e, y);
    check_eq("set_rd0", r, 0);
    check_eq("set_rd_err", 32'(e), 0);
`else
    apb_xfer(1'b1, 8'h18, 32'hF0, r, e, y);
    check_eq("set_unmapped_err", 32'(e), 1);
    apb_xfer(1'b0, 8'h1C, 0, r, e, y);
    check_eq("clr_unmapped_err", 32'(e), 1);
`endif

    // Reset during the access phase aborts the write.
    gpio_in = '0;
    do_reset();
    pad_m = 0;
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 8'h00; pwdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    penable = 1; rst = 1;
    @(posedge clk); #1;
    rst = 0; psel = 0; penable = 0; pwrite = 0;
    apb_xfer(1'b0, 8'h00, 0, r, e, y);
    check_eq("rst_abort", r, 0);
    check_eq("rst_abort_pad", 32'(gpio_out), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int it = 0; it < 120; it++) begin
      int op;
      logic [31:0] d;
      logic [7:0]  a;
      op = $urandom_range(0, 3);
      d  = $urandom;
      case (op)
        0: begin
          a = rw_addrs[$urandom_range(0, 4)];
          apb_xfer(1'b1, a, d, r, e, y);
          model_wr(a, d);
          check_eq($sformatf("rnd_wr_err_%02h", a), 32'(e), 0);
          check_eq("rnd_out", 32'(gpio_out), out_m);
          check_eq("rnd_oe", 32'(gpio_oe), dir_m);
        end
        1: begin
          a = rd_addrs[$urandom_range(0, 5)];
          apb_xfer(1'b0, a, 0, r, e, y);
          check_eq($sformatf("rnd_rd_%02h", a), r, model_rd(a));
        end
        2: begin
          pad_change(d);
          apb_xfer(1'b0, 8'h14, 0, r, e, y);
          check_eq("rnd_stat", r, stat_m);
          repeat (2) @(posedge clk);
          #1;
          check_eq("rnd_irq", 32'(irq), 32'((stat_m & en_m) != 0));
        end
        default: begin
          case ($urandom_range(0, 2))
            0: apb_xfer(1'b1, 8'h08, d, r, e, y);
            1: apb_xfer(1'b0, 8'h20 + 8'($urandom_range(0, 3) * 4) + 8'h04, 0, r, e, y);
            default: apb_xfer(1'b1, 8'h00 + 8'($urandom_range(1, 3)), d, r, e, y);
          endcase
          check_eq("rnd_err", 32'(e), 1);
          check_eq("rnd_err_rd", r, 0);
          apb_xfer(1'b0, 8'h00, 0, r, e, y);
          check_eq("rnd_err_nowr", r, out_m);
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
